// File: rtl/cache_lru_sets.sv
// Multi-set matrix LRU replacement engine with a set-by-set flush sequencer.
// Optional per-set way locking is enabled by defining LRU_LOCK_EN.
module cache_lru_sets #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_valid_i,
    input  logic [SET_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             inv_valid_i,
    input  logic [SET_W-1:0] inv_set_i,
    input  logic [WAY_W-1:0] inv_way_i,
    input  logic             query_valid_i,
    input  logic [SET_W-1:0] query_set_i,
    input  logic             flush_i,
    output logic             victim_valid_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             ready_o
`ifdef LRU_LOCK_EN
    ,
    input  logic                lock_valid_i,
    input  logic [SET_W-1:0]    lock_set_i,
    input  logic [NUM_WAYS-1:0] lock_mask_i,
    output logic                all_locked_o
`endif
);

    typedef logic [NUM_WAYS-1:0][NUM_WAYS-1:0] mat_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [SET_W-1:0]   flush_cnt_r, flush_cnt_nxt_s;
    mat_t               mat_r   [NUM_SETS];
    mat_t               mat_nxt_s [NUM_SETS];
    logic               upd_en_s;
    logic               flushing_s;
    mat_t               q_mat_s;
    logic [NUM_WAYS-1:0] q_cand_s;
    logic [WAY_W-1:0]   q_victim_s;
    logic               victim_valid_r;
    logic [WAY_W-1:0]   victim_way_r;
    logic               ready_r;

    // Touch (row ones, column zeros) then invalidate (row zeros, column ones off-diagonal).
    function automatic mat_t update_mat(input mat_t m, input logic t_hit, input logic [WAY_W-1:0] tw,
                                        input logic i_hit, input logic [WAY_W-1:0] iw, input logic clr);
        mat_t res;
        logic b;
        for (int r = 0; r < NUM_WAYS; r++) begin
            for (int c = 0; c < NUM_WAYS; c++) begin
                b = m[r][c];
                b = (t_hit && (WAY_W'(r) == tw)) ? 1'b1 : b;
                b = (t_hit && (WAY_W'(c) == tw)) ? 1'b0 : b;
                b = (i_hit && (WAY_W'(r) == iw)) ? 1'b0 : b;
                b = (i_hit && (WAY_W'(c) == iw) && (r != c)) ? 1'b1 : b;
                res[r][c] = clr ? 1'b0 : b;
            end
        end
        return res;
    endfunction

    // Lowest candidate way that is not more recent than any other candidate; 0 if none.
    function automatic logic [WAY_W-1:0] pick_victim(input mat_t m, input logic [NUM_WAYS-1:0] cand);
        logic [WAY_W-1:0]    v;
        logic                found;
        logic                hit;
        logic [NUM_WAYS-1:0] cols;
        v = '0;
        found = 1'b0;
        for (int r = 0; r < NUM_WAYS; r++) begin
            cols = cand;
            cols[r] = 1'b0;
            hit = !found && cand[r] && ((m[r] & cols) == '0);
            v = hit ? WAY_W'(r) : v;
            found = found | hit;
        end
        return v;
    endfunction

    assign flushing_s = (state_r == ST_FLUSH);
    assign upd_en_s   = (state_r == ST_IDLE) && !flush_i;

    // Flush sequencer next-state logic.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_nxt_s     = ST_FLUSH;
                    flush_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == SET_W'(NUM_SETS - 1)) begin
                    state_nxt_s     = ST_IDLE;
                    flush_cnt_nxt_s = '0;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r + SET_W'(1);
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                flush_cnt_nxt_s = '0;
            end
        endcase
    end

    // Per-set matrix next state; touch and inv on different sets apply independently.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            mat_nxt_s[s] = update_mat(mat_r[s],
                                      upd_en_s && touch_valid_i && (touch_set_i == SET_W'(s)), touch_way_i,
                                      upd_en_s && inv_valid_i && (inv_set_i == SET_W'(s)), inv_way_i,
                                      flushing_s && (flush_cnt_r == SET_W'(s)));
        end
    end

`ifdef LRU_LOCK_EN
    logic [NUM_WAYS-1:0] lock_r [NUM_SETS];
    logic                all_locked_r;

    // Lock mask storage, cleared alongside its set during flush.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SETS; s++) begin
            if (!rst_n || (flushing_s && (flush_cnt_r == SET_W'(s)))) begin
                lock_r[s] <= '0;
            end else if (upd_en_s && lock_valid_i && (lock_set_i == SET_W'(s))) begin
                lock_r[s] <= lock_mask_i;
            end else begin
                lock_r[s] <= lock_r[s];
            end
        end
    end

    // All-locked flag accompanies each victim pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_locked_r <= 1'b0;
        end else begin
            all_locked_r <= upd_en_s && query_valid_i && (q_cand_s == '0);
        end
    end

    assign all_locked_o = all_locked_r;
`endif

    // Select the queried set's matrix and candidate mask (pre-update state).
    always_comb begin
        q_mat_s  = '0;
        q_cand_s = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            q_mat_s  = q_mat_s | ((query_set_i == SET_W'(s)) ? mat_r[s] : '0);
`ifdef LRU_LOCK_EN
            q_cand_s = q_cand_s | ((query_set_i == SET_W'(s)) ? ~lock_r[s] : '0);
`else
            q_cand_s = '1;
`endif
        end
        q_victim_s = pick_victim(q_mat_s, q_cand_s);
    end

    // State, matrices and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            flush_cnt_r    <= '0;
            victim_valid_r <= 1'b0;
            victim_way_r   <= '0;
            ready_r        <= 1'b1;
            for (int s = 0; s < NUM_SETS; s++) begin
                mat_r[s] <= '0;
            end
        end else begin
            state_r        <= state_nxt_s;
            flush_cnt_r    <= flush_cnt_nxt_s;
            victim_valid_r <= upd_en_s && query_valid_i;
            victim_way_r   <= (upd_en_s && query_valid_i) ? q_victim_s : victim_way_r;
            ready_r        <= (state_nxt_s == ST_IDLE);
            for (int s = 0; s < NUM_SETS; s++) begin
                mat_r[s] <= mat_nxt_s[s];
            end
        end
    end

    assign victim_valid_o = victim_valid_r;
    assign victim_way_o   = victim_way_r;
    assign ready_o        = ready_r;

endmodule

// File: tb/tb_cache_lru_sets.sv
// Directed bench for cache_lru_sets: a recency-stamp model checked every cycle,
// plus hand-computed expectations from the test plan.
module tb_cache_lru_sets;
    localparam int NW = 8;
    localparam int NS = 4;
    localparam int WW = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          touch_valid_i, inv_valid_i, query_valid_i, flush_i;
    logic [SW-1:0] touch_set_i, inv_set_i, query_set_i;
    logic [WW-1:0] touch_way_i, inv_way_i;
    logic          victim_valid_o, ready_o;
    logic [WW-1:0] victim_way_o;
`ifdef LRU_LOCK_EN
    logic          lock_valid_i;
    logic [SW-1:0] lock_set_i;
    logic [NW-1:0] lock_mask_i;
    logic          all_locked_o;
    logic [NW-1:0] lockm [NS];
`endif

    int checks = 0;
    int failures = 0;

    // Model: higher stamp = more recently used; ties mean no order yet.
    int stamp [NS][NW];
    int hi_t = 0;
    int lo_t = 0;
    bit flushing = 1'b0;
    int fcnt = 0;
    bit exp_valid = 1'b0;
    int exp_way = 0;
    bit exp_ready = 1'b1;
    bit exp_all = 1'b0;

    always #5 clk = ~clk;

    cache_lru_sets #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .touch_valid_i(touch_valid_i), .touch_set_i(touch_set_i), .touch_way_i(touch_way_i),
        .inv_valid_i(inv_valid_i), .inv_set_i(inv_set_i), .inv_way_i(inv_way_i),
        .query_valid_i(query_valid_i), .query_set_i(query_set_i), .flush_i(flush_i),
        .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o), .ready_o(ready_o)
`ifdef LRU_LOCK_EN
        , .lock_valid_i(lock_valid_i), .lock_set_i(lock_set_i),
        .lock_mask_i(lock_mask_i), .all_locked_o(all_locked_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_locked(input int s, input int w);
`ifdef LRU_LOCK_EN
        return lockm[s][w];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_victim(input int s, output bit all);
        int best;
        best = -1;
        for (int w = 0; w < NW; w++) begin
            if (!is_locked(s, w) && (best < 0 || stamp[s][w] < stamp[s][best])) best = w;
        end
        all = (best < 0);
        return (best < 0) ? 0 : best;
    endfunction

    task automatic clear_set(input int s);
        for (int w = 0; w < NW; w++) stamp[s][w] = 0;
`ifdef LRU_LOCK_EN
        lockm[s] = '0;
`endif
    endtask

    // One clock: predict outputs from the model, advance it, then compare after the edge.
    task automatic tick();
        bit all;
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) clear_set(s);
            flushing = 1'b0; fcnt = 0; exp_valid = 1'b0; exp_way = 0; exp_all = 1'b0;
        end else if (flushing) begin
            clear_set(fcnt);
            exp_valid = 1'b0; exp_all = 1'b0;
            if (fcnt == NS - 1) begin
                flushing = 1'b0; fcnt = 0;
            end else begin
                fcnt++;
            end
        end else if (flush_i) begin
            flushing = 1'b1; fcnt = 0; exp_valid = 1'b0; exp_all = 1'b0;
        end else begin
            exp_valid = query_valid_i;
            exp_all = 1'b0;
            if (query_valid_i) begin
                exp_way = model_victim(int'(query_set_i), all);
                exp_all = all;
            end
            if (touch_valid_i) begin hi_t++; stamp[touch_set_i][touch_way_i] = hi_t; end
            if (inv_valid_i) begin lo_t--; stamp[inv_set_i][inv_way_i] = lo_t; end
`ifdef LRU_LOCK_EN
            if (lock_valid_i) lockm[lock_set_i] = lock_mask_i;
`endif
        end
        exp_ready = !flushing;
        @(posedge clk);
        #1;
        chk("victim_valid", victim_valid_o, exp_valid);
        chk("victim_way", victim_way_o, exp_way);
        chk("ready", ready_o, exp_ready);
`ifdef LRU_LOCK_EN
        chk("all_locked", all_locked_o, exp_all);
`endif
    endtask

    task automatic idle_inputs();
        touch_valid_i = 1'b0; inv_valid_i = 1'b0; query_valid_i = 1'b0; flush_i = 1'b0;
        touch_set_i = '0; touch_way_i = '0; inv_set_i = '0; inv_way_i = '0; query_set_i = '0;
`ifdef LRU_LOCK_EN
        lock_valid_i = 1'b0; lock_set_i = '0; lock_mask_i = '0;
`endif
    endtask

    task automatic drive(input bit tv, input int ts, input int tw, input bit iv, input int is,
                         input int iw, input bit qv, input int qs, input bit fl);
        touch_valid_i = tv; touch_set_i = SW'(ts); touch_way_i = WW'(tw);
        inv_valid_i = iv; inv_set_i = SW'(is); inv_way_i = WW'(iw);
        query_valid_i = qv; query_set_i = SW'(qs); flush_i = fl;
        tick();
        idle_inputs();
    endtask

    task automatic touch(input int s, input int w); drive(1'b1, s, w, 1'b0, 0, 0, 1'b0, 0, 1'b0); endtask
    task automatic query(input int s);              drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, s, 1'b0); endtask

    task automatic lit_victim(input string name, input int way);
        chk({name, "_valid"}, victim_valid_o, 1'b1);
        chk({name, "_way"}, victim_way_o, way);
    endtask

    initial begin
        for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) stamp[s][w] = 0;
`ifdef LRU_LOCK_EN
        for (int s = 0; s < NS; s++) lockm[s] = '0;
`endif
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_valid", victim_valid_o, 1'b0);
        chk("reset_way", victim_way_o, 0);
        rst_n = 1'b1;

        query(2); lit_victim("reset_query", 0);
        tick(); chk("valid_pulse", victim_valid_o, 1'b0);

        for (int w = 0; w < NW; w++) touch(1, w);
        query(1); lit_victim("set1_order", 0);
        touch(1, 0); query(1); lit_victim("set1_after_touch0", 1);

        for (int w = 0; w < NW; w++) touch(3, w);
        drive(1'b0, 0, 0, 1'b1, 3, 5, 1'b0, 0, 1'b0);
        query(3); lit_victim("set3_inv5", 5);
        touch(3, 5); query(3); lit_victim("set3_touch5", 0);
        drive(1'b1, 3, 5, 1'b1, 3, 5, 1'b0, 0, 1'b0);
        query(3); lit_victim("set3_touch_inv5", 5);

        touch(0, 3);
        for (int w = 0; w < NW; w++) if (w != 3) touch(0, w);
        drive(1'b1, 0, 3, 1'b0, 0, 0, 1'b1, 0, 1'b0); lit_victim("set0_no_bypass", 3);
        query(0); lit_victim("set0_after_touch", 0);

        drive(1'b1, 2, 0, 1'b1, 1, 7, 1'b0, 0, 1'b0);
        query(1); lit_victim("cross_set_inv", 7);
        query(2); lit_victim("cross_set_touch", 1);

        drive(1'b1, 1, 2, 1'b0, 0, 0, 1'b1, 1, 1'b1);
        chk("flush_drops_query", victim_valid_o, 1'b0);
        chk("flush_ready_low", ready_o, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, 1'b1);
        for (int i = 0; i < 2; i++) query(i + 1);
        chk("flush_ready_still_low", ready_o, 1'b0);
        query(3);
        chk("flush_ready_back", ready_o, 1'b1);
        for (int s = 0; s < NS; s++) begin
            query(s); lit_victim($sformatf("post_flush_set%0d", s), 0);
        end

        touch(3, 0); query(3); lit_victim("pre_reset_set3", 1);
        drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("reset_mid_flush_ready", ready_o, 1'b1);
        rst_n = 1'b1;
        query(3); lit_victim("after_reset_set3", 0);

`ifdef LRU_LOCK_EN
        for (int w = 0; w < NW; w++) touch(1, w);
        lock_valid_i = 1'b1; lock_set_i = 2'd1; lock_mask_i = 8'h03;
        tick(); idle_inputs();
        query(1); lit_victim("lock_03", 2);
        chk("lock_03_all", all_locked_o, 1'b0);
        lock_valid_i = 1'b1; lock_set_i = 2'd1; lock_mask_i = 8'hFF;
        tick(); idle_inputs();
        query(1); lit_victim("lock_ff", 0);
        chk("lock_ff_all", all_locked_o, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_lru_sets.md
# cache_lru_sets

Set-associative, matrix-based LRU replacement engine for the L0 cache controller. Holds one NUM_WAYS×NUM_WAYS age matrix per set, updates it on hits, fills and invalidations, and returns the replacement victim for a queried set one cycle after the query. A multi-cycle flush state machine restores every set to its reset ordering. It generalises the single-set LRU to many sets, adds invalidation-driven aging, and optionally supports per-set way locking.

## Interface
- NUM_WAYS, 8: ways per set, power of two, ≥2; WAY_W = $clog2(NUM_WAYS)
- NUM_SETS, 4: sets, power of two, ≥1; SET_W = max(1,$clog2(NUM_SETS))
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- touch_valid_i  in  1  access (hit or fill) to touch_set_i/touch_way_i
- touch_set_i  in  SET_W ; touch_way_i  in  WAY_W
- inv_valid_i  in  1  invalidate inv_set_i/inv_way_i (make it LRU)
- inv_set_i  in  SET_W ; inv_way_i  in  WAY_W
- query_valid_i  in  1  victim request for query_set_i
- query_set_i  in  SET_W
- flush_i  in  1  start full-table flush (pulse)
- victim_valid_o  out  1  victim_way_o valid, one-cycle pulse
- victim_way_o  out  WAY_W  replacement way
- ready_o  out  1  high when IDLE; low while flushing
- lock_valid_i / lock_set_i / lock_mask_i  in  1 / SET_W / NUM_WAYS  (LRU_LOCK_EN only)
- all_locked_o  out  1  (LRU_LOCK_EN only) every way of queried set locked

## Operation
- Per set s, matrix M[s][r][c]. M[r][c]=1 means way r was used more recently than way c. The diagonal is ignored.
- Touch way w: row w set to all ones, then column w cleared (diagonal ends at 0). w becomes MRU.
- Invalidate way w: row w cleared, then column w set to ones (except the diagonal). w becomes LRU.
- Victim: the lowest-index way whose row is zero over all candidate columns. Candidates are all ways, or only unlocked ways under LRU_LOCK_EN.
- Reset / flush state: all matrices zero. Victim = way 0 until touches create an order.
- Same-cycle ordering on the same set: touch is applied first, then invalidate. If touch and invalidate hit the same way, the net result is that way is LRU.
- Touch and invalidate on different sets are applied independently in the same cycle.
- FSM IDLE, FLUSH:
  - IDLE→FLUSH on flush_i. FLUSH clears one set per cycle using a counter 0..NUM_SETS-1. FLUSH→IDLE after set NUM_SETS-1.
  - flush_i has priority over touch, inv and query in its launch cycle; all three are dropped.
  - In FLUSH, touch, inv, query and lock requests are ignored, and victim_valid_o stays 0.
  - flush_i while already in FLUSH is ignored; the counter does not restart.
- Reset mid-flush: FSM returns to IDLE and all matrices and lock masks are cleared immediately.

## Timing
- Reset values: victim_valid_o=0, victim_way_o=0, ready_o=1, all_locked_o=0, FSM=IDLE, counter=0, matrices=0, lock masks=0.
- Query latency: 1 cycle, registered outputs. The victim is computed from matrix state before that cycle's touch/inv update; there is no bypass.
- A touch or inv in cycle N is visible to a query issued in cycle N+1.
- ready_o drops the cycle after flush_i is sampled. It stays low for exactly NUM_SETS cycles.
- victim_way_o holds its last value when victim_valid_o=0.

## Configuration
- LRU_LOCK_EN defined:
  - Per-set NUM_WAYS-bit lock mask register, written on lock_valid_i with one-cycle latency.
  - Locked ways are still aged by touch/inv, but are excluded from victim selection, both as candidates and as comparison columns.
  - If all ways are locked: victim_valid_o=1, victim_way_o=0, all_locked_o=1.
  - Flush clears the lock masks.
- LRU_LOCK_EN undefined: lock ports and all_locked_o are absent, no mask storage exists, and every way is a candidate.

## Test plan
- After reset, query set 2 → next cycle victim_valid_o=1, victim_way_o=0.
- NUM_WAYS=8, set 1: touch ways 0..7 in order, then query → victim 0. Then touch 0 and query → victim 1.
- Set 3: touch all ways, invalidate way 5, query → victim 5. Same-cycle touch 5 and inv 5 → victim 5.
- Touch set 0 way 3 in the same cycle as a query of set 0 → the victim reflects the pre-touch state. A query in the next cycle reflects the touch.
- flush_i with NUM_SETS=4 → ready_o low for 4 cycles, queries during flush give no victim_valid_o, every set afterwards returns victim 0. Reset asserted on flush cycle 2 → ready_o=1 the next cycle.
- LRU_LOCK_EN: lock mask 8'h03 on set 1 after touching 0..7 → victim 2. Mask 8'hFF → all_locked_o=1, victim 0.
